// File: rtl/vpu_readback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : vpu_readback_unit
//  Purpose  : CPU read-object return path: object lookup, arbitrated memory
//             read, record unpack to V0..V7/RO with a one-cycle data_we strobe.
//  Revision : 1.0
// ============================================================================
module vpu_readback_unit #(
    parameter int OBJ_W          = 144,
    parameter int WORD_W         = 16,
    parameter int ADDR_W         = 5,
    parameter int MEM_LAT        = 1,
    parameter int LOOKUP_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W-1:0] obj_num_in,
    output logic              ref_addr,
    output logic [ADDR_W-1:0] obj_num_out,
    input  logic              addr_vld,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [OBJ_W-1:0]  mem_obj_in,
    output logic              busy,
    output logic              data_we,
    output logic              err,
    output logic [WORD_W-1:0] V0,
    output logic [WORD_W-1:0] V1,
    output logic [WORD_W-1:0] V2,
    output logic [WORD_W-1:0] V3,
    output logic [WORD_W-1:0] V4,
    output logic [WORD_W-1:0] V5,
    output logic [WORD_W-1:0] V6,
    output logic [WORD_W-1:0] V7,
    output logic [WORD_W-1:0] RO
);

    localparam int c_n_words = 9;
    localparam int c_to_w    = (LOOKUP_TIMEOUT > 1) ? $clog2(LOOKUP_TIMEOUT) : 1;
    localparam int c_lat_w   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(LOOKUP_TIMEOUT - 1);
    localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(MEM_LAT - 1);
    localparam logic [WORD_W-1:0]  c_err_ro   = {WORD_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_ARB    = 3'd2,
        S_READ   = 3'd3,
        S_ERR    = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_to_w-1:0]   r_to_cnt;
    logic [c_lat_w-1:0]  r_lat_cnt;
    logic                r_ref_addr;
    logic [ADDR_W-1:0]   r_obj_num;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_err;
    logic [WORD_W-1:0]   r_word [c_n_words];
    logic                w_lat_done;

    assign w_lat_done = (r_lat_cnt == c_lat_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        data_we   = 1'b0;
        mem_rd_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (go) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (addr_vld)                    w_next = S_ARB;
                else if (r_to_cnt == c_to_last)  w_next = S_ERR;
            end
            S_ARB: begin
                // The matrix engine has priority on the shared read port.
                if (!mem_busy) begin
                    mem_rd_en = 1'b1;
                    w_next    = S_READ;
                end
            end
            S_READ:  if (w_lat_done) w_next = S_RESP;
            S_ERR:   w_next = S_RESP;
            S_RESP: begin
                data_we = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt   <= '0;
            r_lat_cnt  <= '0;
            r_ref_addr <= 1'b0;
            r_obj_num  <= '0;
            r_mem_addr <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < c_n_words; i++) r_word[i] <= '0;
        end else begin
            r_ref_addr <= (r_state == S_IDLE) && go;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_obj_num <= obj_num_in;
                        r_to_cnt  <= '0;
                    end
                end
                S_LOOKUP: begin
                    if (addr_vld) r_mem_addr <= addr;
                    else          r_to_cnt   <= r_to_cnt + 1'b1;
                end
                S_ARB: r_lat_cnt <= '0;
                S_READ: begin
                    if (w_lat_done) begin
                        // Word 0 (V0) sits in the most significant slice.
                        for (int i = 0; i < c_n_words; i++)
                            r_word[i] <= mem_obj_in[OBJ_W-1-i*WORD_W -: WORD_W];
                        r_err <= 1'b0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                S_ERR: begin
                    for (int i = 0; i < c_n_words - 1; i++) r_word[i] <= '0;
                    r_word[c_n_words-1] <= c_err_ro;
                    r_err               <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ref_addr    = r_ref_addr;
    assign obj_num_out = r_obj_num;
    assign mem_addr    = r_mem_addr;
    assign err         = r_err;
    assign V0          = r_word[0];
    assign V1          = r_word[1];
    assign V2          = r_word[2];
    assign V3          = r_word[3];
    assign V4          = r_word[4];
    assign V5          = r_word[5];
    assign V6          = r_word[6];
    assign V7          = r_word[7];
    assign RO          = r_word[8];

endmodule
`default_nettype wire
